// File: rtl/upd_pad_glue.sv
// upd_pad_glue: UPduino pad cells, PLL-lock reset generator and warm-boot request unit.
// Latency: bus/video/intr pads 1 clk; bus_data_o 0 or 1 clk (REG_INPUT); boot strobe 2 clk after reconfig_i rises.
// Backpressure: none; every path accepts a new value on every clk.
module upd_pad_glue #(
  parameter int RESET_HOLD = 4,
  parameter int REG_INPUT  = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        pll_lock_i,
  output logic        rst_o,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic [7:0]  bus_pad_i,
  output logic [7:0]  bus_pad_o,
  output logic        bus_pad_oe_o,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  input  logic        intr_i,
  output logic        intr_o,
  input  logic        dv_de_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic [3:0]  red_i,
  input  logic [3:0]  green_i,
  input  logic [3:0]  blue_i,
  output logic [14:0] video_pad_o,
  output logic        dv_clk_o,
  input  logic        reconfig_i,
  input  logic [1:0]  boot_select_i,
  output logic        boot_req_o,
  output logic [1:0]  boot_image_o,
  output logic        boot_pending_o
);

  localparam logic [7:0] HOLD = 8'(RESET_HOLD);

  logic [7:0] hold_cnt;
  logic       dv_rise;
  logic       dv_fall;
  logic       reconfig_r;
  logic       reconfig_d;
  logic [1:0] bsel_r;
  logic       reconfig_rise;

  // Core reset: held while unlocked, released on the edge that sees the count at RESET_HOLD.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      rst_o    <= 1'b1;
      hold_cnt <= '0;
    end else if (!pll_lock_i) begin
      rst_o    <= 1'b1;
      hold_cnt <= '0;
    end else begin
      rst_o <= (hold_cnt != HOLD);
      if (hold_cnt != HOLD) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  // Host bus drives the pins only for a selected read cycle.
  assign bus_pad_oe_o = !bus_cs_n_i && bus_rd_nwr_i;

  // Output pad flops: read data, interrupt and video all register once.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      bus_pad_o   <= '0;
      intr_o      <= 1'b0;
      video_pad_o <= '0;
    end else begin
      bus_pad_o   <= bus_data_i;
      intr_o      <= intr_i;
      video_pad_o <= {dv_de_i, vsync_i, hsync_i, red_i, green_i, blue_i};
    end
  end

  generate
    if (REG_INPUT != 0) begin : g_in_reg
      // Registered input pad for the host write data.
      always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
          bus_data_o <= '0;
        end else begin
          bus_data_o <= bus_pad_i;
        end
      end
    end else begin : g_in_comb
      assign bus_data_o = bus_pad_i;
    end
  endgenerate

  // DDR pixel clock, rising-edge half: the pad drives 0 while clk is high.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      dv_rise <= 1'b0;
    end else begin
      dv_rise <= 1'b0;
    end
  end

  // DDR pixel clock, falling-edge half: the pad drives 1 while clk is low, 0 in reset.
  always_ff @(negedge clk or posedge reset_i) begin
    if (reset_i) begin
      dv_fall <= 1'b0;
    end else begin
      dv_fall <= 1'b1;
    end
  end

  // The DDR pad selects the half matching the current clk phase, giving ~clk.
  assign dv_clk_o = clk ? dv_rise : dv_fall;

  assign reconfig_rise = reconfig_r && !reconfig_d;

  // Warm boot: one strobe on the first staged reconfig rise, then frozen until reset_i.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      reconfig_r     <= 1'b0;
      reconfig_d     <= 1'b0;
      bsel_r         <= '0;
      boot_req_o     <= 1'b0;
      boot_image_o   <= '0;
      boot_pending_o <= 1'b0;
    end else begin
      reconfig_r <= reconfig_i;
      reconfig_d <= reconfig_r;
      bsel_r     <= boot_select_i;
      boot_req_o <= reconfig_rise && !boot_pending_o;
      if (reconfig_rise && !boot_pending_o) begin
        boot_image_o   <= bsel_r;
        boot_pending_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upd_pad_glue.sv
// tb_upd_pad_glue: directed test-plan cases plus randomized traffic against a cycle model.
// Latency: inputs driven at negedge, comb outputs checked at negedge+1, registered at posedge+1.
// Backpressure: none.
module tb_upd_pad_glue;
  localparam int RESET_HOLD = 4;
  localparam int REG_INPUT  = 0;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        pll_lock_i = 1'b0;
  logic        rst_o;
  logic        bus_cs_n_i = 1'b1;
  logic        bus_rd_nwr_i = 1'b0;
  logic [7:0]  bus_pad_i = '0;
  logic [7:0]  bus_pad_o;
  logic        bus_pad_oe_o;
  logic [7:0]  bus_data_i = '0;
  logic [7:0]  bus_data_o;
  logic        intr_i = 1'b0;
  logic        intr_o;
  logic        dv_de_i = 1'b0;
  logic        vsync_i = 1'b0;
  logic        hsync_i = 1'b0;
  logic [3:0]  red_i = '0;
  logic [3:0]  green_i = '0;
  logic [3:0]  blue_i = '0;
  logic [14:0] video_pad_o;
  logic        dv_clk_o;
  logic        reconfig_i = 1'b0;
  logic [1:0]  boot_select_i = '0;
  logic        boot_req_o;
  logic [1:0]  boot_image_o;
  logic        boot_pending_o;

  upd_pad_glue #(.RESET_HOLD(RESET_HOLD), .REG_INPUT(REG_INPUT)) dut (
    .clk(clk), .reset_i(reset_i), .pll_lock_i(pll_lock_i), .rst_o(rst_o),
    .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i), .bus_pad_i(bus_pad_i),
    .bus_pad_o(bus_pad_o), .bus_pad_oe_o(bus_pad_oe_o), .bus_data_i(bus_data_i),
    .bus_data_o(bus_data_o), .intr_i(intr_i), .intr_o(intr_o),
    .dv_de_i(dv_de_i), .vsync_i(vsync_i), .hsync_i(hsync_i),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .video_pad_o(video_pad_o),
    .dv_clk_o(dv_clk_o), .reconfig_i(reconfig_i), .boot_select_i(boot_select_i),
    .boot_req_o(boot_req_o), .boot_image_o(boot_image_o), .boot_pending_o(boot_pending_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int req_seen = 0;

  // Reference model state: edges of continuous lock, reconfig/select history, expected pads.
  int          lock_run;
  bit          pend;
  logic [1:0]  img;
  bit          rc_hist1, rc_hist2;
  logic [1:0]  bs_hist1;
  logic        e_rst, e_intr, e_req;
  logic [7:0]  e_pad, e_din_reg;
  logic [14:0] e_video;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    lock_run = 0; pend = 0; img = '0;
    rc_hist1 = 0; rc_hist2 = 0; bs_hist1 = '0;
    e_rst = 1'b1; e_intr = 1'b0; e_req = 1'b0;
    e_pad = '0; e_din_reg = '0; e_video = '0;
  endtask

  // One clk with the currently driven inputs; entered and left just after a negedge.
  task automatic cycle();
    logic [7:0] exp_din;
    #1;
    exp_din = (REG_INPUT != 0) ? e_din_reg : bus_pad_i;
    chk("oe", 32'(bus_pad_oe_o), 32'(!bus_cs_n_i && bus_rd_nwr_i));
    chk("bus_data_o", 32'(bus_data_o), 32'(exp_din));
    chk("dv_clk_low_phase", 32'(dv_clk_o), 32'd1);
    @(posedge clk);
    if (pll_lock_i) lock_run++; else lock_run = 0;
    e_rst     = (lock_run <= RESET_HOLD);
    e_pad     = bus_data_i;
    e_din_reg = bus_pad_i;
    e_intr    = intr_i;
    e_video   = {dv_de_i, vsync_i, hsync_i, red_i, green_i, blue_i};
    e_req     = !pend && rc_hist1 && !rc_hist2;
    if (e_req) begin
      pend = 1;
      img  = bs_hist1;
    end
    rc_hist2 = rc_hist1; rc_hist1 = reconfig_i; bs_hist1 = boot_select_i;
    #1;
    if (boot_req_o) req_seen++;
    chk("rst_o", 32'(rst_o), 32'(e_rst));
    chk("bus_pad_o", 32'(bus_pad_o), 32'(e_pad));
    chk("intr_o", 32'(intr_o), 32'(e_intr));
    chk("video_pad_o", 32'(video_pad_o), 32'(e_video));
    chk("boot_req_o", 32'(boot_req_o), 32'(e_req));
    chk("boot_image_o", 32'(boot_image_o), 32'(img));
    chk("boot_pending_o", 32'(boot_pending_o), 32'(pend));
    chk("dv_clk_high_phase", 32'(dv_clk_o), 32'd0);
    @(negedge clk);
  endtask

  // Assert reset_i mid-cycle, check the reset state in both clk phases, release after a posedge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset_i = 1'b1;
    model_reset();
    #1;
    chk("rst_in_reset", 32'(rst_o), 32'd1);
    chk("pad_in_reset", 32'(bus_pad_o), 32'd0);
    chk("intr_in_reset", 32'(intr_o), 32'd0);
    chk("video_in_reset", 32'(video_pad_o), 32'd0);
    chk("boot_in_reset", 32'({boot_req_o, boot_image_o, boot_pending_o}), 32'd0);
    chk("dv_hi_in_reset", 32'(dv_clk_o), 32'd0);
    @(negedge clk);
    #1 chk("dv_lo_in_reset", 32'(dv_clk_o), 32'd0);
    @(posedge clk);
    #2 reset_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Reset generator: no lock, then lock for RESET_HOLD+1 edges, then a drop.
    pll_lock_i = 1'b0;
    repeat (3) cycle();
    chk("rst_no_lock", 32'(rst_o), 32'd1);
    pll_lock_i = 1'b1;
    for (int k = 1; k <= RESET_HOLD + 1; k++) begin
      cycle();
      if (k == RESET_HOLD) chk("rst_still_held", 32'(rst_o), 32'd1);
    end
    chk("rst_released", 32'(rst_o), 32'd0);
    pll_lock_i = 1'b0;
    cycle();
    chk("rst_lock_lost", 32'(rst_o), 32'd1);
    pll_lock_i = 1'b1;
    repeat (RESET_HOLD + 2) cycle();

    // Bus read then write.
    bus_cs_n_i = 1'b0; bus_rd_nwr_i = 1'b1; bus_data_i = 8'hA5;
    #1 chk("oe_read", 32'(bus_pad_oe_o), 32'd1);
    cycle();
    chk("pad_read", 32'(bus_pad_o), 32'hA5);
    bus_rd_nwr_i = 1'b0; bus_pad_i = 8'h3C;
    #1 chk("oe_write", 32'(bus_pad_oe_o), 32'd0);
    cycle();
    chk("din_write", 32'(bus_data_o), 32'h3C);

    // Video pattern and interrupt pulse.
    dv_de_i = 1'b1; vsync_i = 1'b0; hsync_i = 1'b1;
    red_i = 4'hF; green_i = 4'h0; blue_i = 4'hA; intr_i = 1'b1;
    cycle();
    chk("video_pattern", 32'(video_pad_o), 32'(15'b101_1111_0000_1010));
    chk("intr_pulse_hi", 32'(intr_o), 32'd1);
    intr_i = 1'b0;
    cycle();
    chk("intr_pulse_lo", 32'(intr_o), 32'd0);

    // Warm boot: first request latches image 2, a later one with select 1 is ignored.
    req_seen = 0;
    boot_select_i = 2'd2; reconfig_i = 1'b1;
    cycle();
    chk("boot_not_yet", 32'(boot_req_o), 32'd0);
    reconfig_i = 1'b0;
    cycle();
    chk("boot_strobe", 32'(boot_req_o), 32'd1);
    repeat (3) cycle();
    boot_select_i = 2'd1; reconfig_i = 1'b1;
    repeat (2) cycle();
    reconfig_i = 1'b0;
    repeat (3) cycle();
    chk("boot_strobe_count", 32'(req_seen), 32'd1);
    chk("boot_image_frozen", 32'(boot_image_o), 32'd2);
    chk("boot_pending_set", 32'(boot_pending_o), 32'd1);
    do_reset();

    // Randomized traffic with occasional lock loss, reconfig toggles and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      pll_lock_i    = ($urandom_range(0, 24) != 0);
      bus_cs_n_i    = 1'($urandom_range(0, 1));
      bus_rd_nwr_i  = 1'($urandom_range(0, 1));
      bus_pad_i     = 8'($urandom_range(0, 255));
      bus_data_i    = 8'($urandom_range(0, 255));
      intr_i        = 1'($urandom_range(0, 1));
      dv_de_i       = 1'($urandom_range(0, 1));
      vsync_i       = 1'($urandom_range(0, 1));
      hsync_i       = 1'($urandom_range(0, 1));
      red_i         = 4'($urandom_range(0, 15));
      green_i       = 4'($urandom_range(0, 15));
      blue_i        = 4'($urandom_range(0, 15));
      boot_select_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) reconfig_i = ~reconfig_i;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
